// File: rtl/aes_pkg.sv
// Shared AES types and byte substitution tables (FIPS-197 S-box and its inverse).
package aes_pkg;

  typedef logic [7:0]       byte_t;
  typedef logic [15:0][7:0] state_t;

  localparam int STATE_BYTES = 16;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sbox.sv
// Single-byte combinational inverse S-box lookup.
module inv_sbox
  import aes_pkg::*;
(
  input  byte_t val,
  output byte_t sub
);

  assign sub = INV_SBOX[val];

endmodule

// File: rtl/inv_substitute_iter.sv
// Iterative InvSubBytes: BYTES_PER_CYCLE shared inverse S-boxes walk the
// working register from byte 15 downward, then hold the result for the consumer.
module inv_substitute_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0][7:0] state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0][7:0] newstate,
  output logic             busy
);

  localparam int CHUNKS = STATE_BYTES / BYTES_PER_CYCLE;
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  generate
    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
      $error("inv_substitute_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t             fsm_reg, fsm_next;
  state_t           work_reg, work_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  byte_t lut_in  [BYTES_PER_CYCLE];
  byte_t lut_out [BYTES_PER_CYCLE];

  // Lane gi of the current chunk handles byte 15 - idx*B - gi.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_lane
      assign lut_in[gi] = work_reg[4'(15 - int'(idx_reg) * BYTES_PER_CYCLE - gi)];
      inv_sbox u_inv_sbox (
        .val (lut_in[gi]),
        .sub (lut_out[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg  <= IDLE;
      work_reg <= '0;
      idx_reg  <= '0;
    end else begin
      fsm_reg  <= fsm_next;
      work_reg <= work_next;
      idx_reg  <= idx_next;
    end
  end

  always_comb begin
    fsm_next  = fsm_reg;
    work_next = work_reg;
    idx_next  = idx_reg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_reg)
      IDLE: begin
        in_ready = !reset;
        if (in_valid) begin
          work_next = state;
          idx_next  = '0;
          fsm_next  = RUN;
        end
      end
      RUN: begin
        busy = !reset;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
          work_next[4'(15 - int'(idx_reg) * BYTES_PER_CYCLE - j)] = lut_out[j];
        end
        idx_next = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          fsm_next = DONE;
        end
      end
      DONE: begin
        out_valid = !reset;
        if (out_ready) begin
          fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign newstate = work_reg;

endmodule

// File: tb/tb_inv_substitute_iter.sv
// Self-checking bench: five engines (B = 1,2,4,8,16) against a GF(2^8)-derived S-box model.
module tb_inv_substitute_iter;

  typedef logic [15:0][7:0] st_t;

  logic clk = 1'b0;
  logic reset;
  logic iv  [5];
  logic ir  [5];
  logic ov  [5];
  logic orr [5];
  logic bz  [5];
  st_t  st  [5];
  st_t  ns  [5];

  int checks   = 0;
  int failures = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_dut
      inv_substitute_iter #(.BYTES_PER_CYCLE(1 << gi)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (iv[gi]),
        .in_ready  (ir[gi]),
        .state     (st[gi]),
        .out_valid (ov[gi]),
        .out_ready (orr[gi]),
        .newstate  (ns[gi]),
        .busy      (bz[gi])
      );
    end
  endgenerate

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_tables();
    logic [7:0] y, s;
    for (int x = 0; x < 256; x++) begin
      y = 8'h00;
      if (x != 0) begin
        for (int c = 1; c < 256; c++) begin
          if (gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
        end
      end
      s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic st_t model_inv(input st_t s);
    st_t r;
    for (int i = 0; i < 16; i++) r[i] = inv_tab[s[i]];
    return r;
  endfunction

  function automatic st_t model_fwd(input st_t s);
    st_t r;
    for (int i = 0; i < 16; i++) r[i] = fwd_tab[s[i]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One transaction with out_ready held high; optionally scrambles the input after accept.
  task automatic do_txn(input int k, input st_t s, input bit scramble,
                        output st_t res, output int lat);
    int guard = 0;
    orr[k] = 1'b1;
    iv[k]  = 1'b1;
    st[k]  = s;
    while (!ir[k] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    iv[k] = 1'b0;
    if (scramble) st[k] = '1;
    lat = 0;
    while (!ov[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = ns[k];
    @(posedge clk); #1;
    orr[k] = 1'b0;
    $display("txn B=%0d in=%h out=%h lat=%0d", 1 << k, s, res, lat);
  endtask

  st_t fips_in, fips_out, res, a_st, b_st, held;
  int  lat, g;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fips_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
    fips_out = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      iv[k] = 1'b0; orr[k] = 1'b0; st[k] = '0;
    end
    build_tables();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rst_in_ready_B%0d", 1 << k), 128'(ir[k]), 128'(0));
      chk($sformatf("rst_out_valid_B%0d", 1 << k), 128'(ov[k]), 128'(0));
      chk($sformatf("rst_busy_B%0d", 1 << k), 128'(bz[k]), 128'(0));
    end
    reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("post_rst_in_ready_B%0d", 1 << k), 128'(ir[k]), 128'(1));
      chk($sformatf("post_rst_newstate_B%0d", 1 << k), ns[k], 128'(0));
    end

    // FIPS-197 vector, default width
    do_txn(2, fips_in, 1'b0, res, lat);
    chk("fips_result", res, fips_out);
    chk("fips_model", res, model_inv(fips_in));
    chk("fips_latency", 128'(lat), 128'(4));
    chk("fips_in_ready_after", 128'(ir[2]), 128'(1));

    // Constant inputs on every width
    for (int k = 0; k < 5; k++) begin
      do_txn(k, {16{8'h63}}, 1'b0, res, lat);
      chk($sformatf("all63_B%0d", 1 << k), res, 128'(0));
      chk($sformatf("all63_lat_B%0d", 1 << k), 128'(lat), 128'(16 >> k));
      do_txn(k, '0, 1'b0, res, lat);
      chk($sformatf("all00_B%0d", 1 << k), res, {16{8'h52}});
      chk($sformatf("all00_lat_B%0d", 1 << k), 128'(lat), 128'(16 >> k));
    end

    // Exhaustive byte sweep with round trip
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 16; i++) a_st[i] = 8'(t * 16 + i);
      do_txn(2, a_st, 1'b0, res, lat);
      chk($sformatf("sweep_%0d", t), res, model_inv(a_st));
      chk($sformatf("sweep_rt_%0d", t), model_fwd(res), a_st);
    end

    // Random states on random widths
    for (int n = 0; n < 20; n++) begin
      int k;
      k = int'($urandom_range(0, 4));
      a_st = {$urandom, $urandom, $urandom, $urandom};
      do_txn(k, a_st, 1'b0, res, lat);
      chk($sformatf("rand_%0d_B%0d", n, 1 << k), res, model_inv(a_st));
      chk($sformatf("rand_lat_%0d", n), 128'(lat), 128'(16 >> k));
    end

    // Input changed after accept
    a_st = {$urandom, $urandom, $urandom, $urandom};
    do_txn(2, a_st, 1'b1, res, lat);
    chk("scramble_B4", res, model_inv(a_st));
    do_txn(0, fips_in, 1'b1, res, lat);
    chk("scramble_B1", res, fips_out);

    // Backpressure with a second request waiting
    a_st = {$urandom, $urandom, $urandom, $urandom};
    b_st = {$urandom, $urandom, $urandom, $urandom};
    orr[2] = 1'b0; iv[2] = 1'b1; st[2] = a_st;
    @(posedge clk); #1;
    iv[2] = 1'b0;
    g = 0;
    while (!ov[2] && g < 40) begin @(posedge clk); #1; g++; end
    chk("bp_latency", 128'(g), 128'(4));
    held = ns[2];
    chk("bp_result", held, model_inv(a_st));
    st[2] = b_st; iv[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_%0d", c), ns[2], held);
      chk($sformatf("bp_out_valid_%0d", c), 128'(ov[2]), 128'(1));
      chk($sformatf("bp_in_ready_%0d", c), 128'(ir[2]), 128'(0));
    end
    orr[2] = 1'b1;
    @(posedge clk); #1;
    orr[2] = 1'b0;
    chk("bp_idle_in_ready", 128'(ir[2]), 128'(1));
    chk("bp_not_yet_busy", 128'(bz[2]), 128'(0));
    @(posedge clk); #1;
    iv[2] = 1'b0;
    chk("bp_second_accepted", 128'(bz[2]), 128'(1));
    g = 0;
    while (!ov[2] && g < 40) begin @(posedge clk); #1; g++; end
    chk("bp_second_result", ns[2], model_inv(b_st));
    $display("txn B=4 in=%h out=%h lat=%0d (second after backpressure)", b_st, ns[2], g);
    orr[2] = 1'b1;
    @(posedge clk); #1;
    orr[2] = 1'b0;

    // Reset mid-RUN after two chunks
    iv[2] = 1'b1; st[2] = {16{8'h63}};
    @(posedge clk); #1;
    iv[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrun_busy", 128'(bz[2]), 128'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrun_out_valid", 128'(ov[2]), 128'(0));
    chk("midrun_newstate", ns[2], 128'(0));
    chk("midrun_busy_cleared", 128'(bz[2]), 128'(0));
    chk("midrun_in_ready_low", 128'(ir[2]), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrun_in_ready_after", 128'(ir[2]), 128'(1));
    do_txn(2, fips_in, 1'b0, res, lat);
    chk("midrun_fips_result", res, fips_out);
    chk("midrun_fips_latency", 128'(lat), 128'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
